tri_scheduler: RTL

Per-frame triangle sequencer that feeds the rasterizer. On each `new_frame_in` pulse it walks the triangle index list, fetches three vertex indices and then three packed vertices from block RAM, and presents each triangle on a valid/ready handshake. After the last triangle it pulses `obj_done_out`. It sits between the vertex/index memories and the rasterizer, which runs in the pixel clock domain.

---
 rtl/tri_pkg.sv | 23 ++
 rtl/tri_area.sv | 27 ++
 rtl/tri_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tri_pkg.sv
// Shared types for the triangle scheduler: vertex record, FSM state encoding, default coordinate width.
package tri_pkg;

    localparam int COORD_W_DEF = 9;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] z;
    } vertex_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_IDX = 3'd1,
        ST_FETCH_VTX = 3'd2,
        ST_PRESENT   = 3'd3,
        ST_DONE      = 3'd4
`ifdef BACKFACE_CULL_EN
        , ST_CULL    = 3'd5
`endif
    } sched_state_t;

endpackage

// File: rtl/tri_area.sv
// Signed doubled triangle area A = (x2-x1)(y3-y1) - (x3-x1)(y2-y1); positive means front-facing.
module tri_area #(
    parameter int COORD_W = 9
) (
    input  logic [2:0][COORD_W-1:0]      v1_i,
    input  logic [2:0][COORD_W-1:0]      v2_i,
    input  logic [2:0][COORD_W-1:0]      v3_i,
    output logic signed [2*COORD_W+2:0]  area_o
);
    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;
    localparam int SW = 2 * COORD_W + 3;

    logic signed [DW-1:0] dx21, dy31, dx31, dy21;
    logic signed [PW-1:0] prod_a, prod_b;

    // Coordinates are unsigned; a zero MSB keeps them positive before subtraction.
    assign dx21 = $signed({1'b0, v2_i[2]}) - $signed({1'b0, v1_i[2]});
    assign dy31 = $signed({1'b0, v3_i[1]}) - $signed({1'b0, v1_i[1]});
    assign dx31 = $signed({1'b0, v3_i[2]}) - $signed({1'b0, v1_i[2]});
    assign dy21 = $signed({1'b0, v2_i[1]}) - $signed({1'b0, v1_i[1]});

    assign prod_a = PW'(dx21) * PW'(dy31);
    assign prod_b = PW'(dx31) * PW'(dy21);
    assign area_o = SW'(prod_a) - SW'(prod_b);

endmodule

// File: rtl/tri_scheduler.sv
// Walks the index list each frame, fetches three vertices per triangle and presents them on valid/ready.
// Define BACKFACE_CULL_EN to add a CULL state that drops triangles with non-positive signed area.
module tri_scheduler
    import tri_pkg::*;
#(
    parameter int NUM_VERTICES = 8,
    parameter int NUM_TRIS     = 12,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             new_frame_in,
    output logic [$clog2(3*NUM_TRIS)-1:0]    idx_addr_out,
    input  logic [$clog2(NUM_VERTICES)-1:0]  idx_data_in,
    output logic [$clog2(NUM_VERTICES)-1:0]  vtx_addr_out,
    input  logic [3*COORD_W-1:0]             vtx_data_in,
    output logic [2:0][COORD_W-1:0]          vert1_out,
    output logic [2:0][COORD_W-1:0]          vert2_out,
    output logic [2:0][COORD_W-1:0]          vert3_out,
    output logic                             tri_valid_out,
    input  logic                             tri_ready_in,
    output logic                             obj_done_out,
    output logic                             busy_out,
    output logic                             overrun_out
);
    localparam int IAW = $clog2(3 * NUM_TRIS);
    localparam int VAW = $clog2(NUM_VERTICES);
    localparam int TW  = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
    localparam int KW  = $clog2(RAM_LATENCY + 3);
    localparam logic [KW-1:0] K_LAST = KW'(RAM_LATENCY + 2);
    localparam logic [TW-1:0] T_LAST = TW'(NUM_TRIS - 1);
    localparam logic [31:0]   NV_U   = 32'(NUM_VERTICES);

    sched_state_t state_q, state_d;

    logic [TW-1:0]                  t_q, t_d;
    logic [KW-1:0]                  k_q, k_d;
    logic [IAW-1:0]                 idx_addr_q, idx_addr_d;
    logic [VAW-1:0]                 vtx_addr_q, vtx_addr_d;
    logic [2:0][VAW-1:0]            idx_q, idx_d;
    logic [2:0][2:0][COORD_W-1:0]   vert_q, vert_d;
    logic                           valid_q, valid_d;
    logic                           done_q, done_d;
    logic                           busy_q, busy_d;
    logic                           overrun_q, overrun_d;

    logic       phase_end, last_tri, frame_abort, idx_bad, cull_reject, tri_end;
    logic [2:0] idx_ok;

    assign phase_end   = (k_q == K_LAST);
    assign last_tri    = (t_q == T_LAST);
    assign frame_abort = new_frame_in && (state_q != ST_IDLE) && (state_q != ST_DONE);

    // The third index is checked straight off the RAM bus on the edge it is captured.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_range
            logic [VAW-1:0] cand;
            assign cand       = (gi == 2) ? idx_data_in : idx_q[gi];
            assign idx_ok[gi] = (32'(cand) < NV_U);
        end
    endgenerate
    assign idx_bad = (state_q == ST_FETCH_IDX) && phase_end && !(&idx_ok);

`ifdef BACKFACE_CULL_EN
    logic signed [2*COORD_W+2:0] area;

    tri_area #(.COORD_W(COORD_W)) u_area (
        .v1_i   (vert_q[0]),
        .v2_i   (vert_q[1]),
        .v3_i   (vert_q[2]),
        .area_o (area)
    );
    assign cull_reject = (state_q == ST_CULL) && (area[2*COORD_W+2] || (area == '0));
`else
    assign cull_reject = 1'b0;
`endif

    // A triangle finishes by transfer, by a bad index, or by being culled.
    assign tri_end = idx_bad || cull_reject || ((state_q == ST_PRESENT) && tri_ready_in);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (new_frame_in) state_d = ST_FETCH_IDX;
            ST_FETCH_IDX: if (phase_end) state_d = ST_FETCH_VTX;
`ifdef BACKFACE_CULL_EN
            ST_FETCH_VTX: if (phase_end) state_d = ST_CULL;
            ST_CULL:      state_d = ST_PRESENT;
`else
            ST_FETCH_VTX: if (phase_end) state_d = ST_PRESENT;
`endif
            ST_PRESENT:   state_d = ST_PRESENT;
            ST_DONE:      state_d = new_frame_in ? ST_FETCH_IDX : ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (tri_end) state_d = last_tri ? ST_DONE : ST_FETCH_IDX;
        if (frame_abort) state_d = ST_FETCH_IDX;
    end

    always_comb begin
        t_d        = t_q;
        k_d        = k_q;
        idx_addr_d = idx_addr_q;
        vtx_addr_d = vtx_addr_q;
        idx_d      = idx_q;
        vert_d     = vert_q;
        valid_d    = (state_d == ST_PRESENT);
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        overrun_d  = overrun_q | frame_abort;

        if (new_frame_in) begin
            t_d        = '0;
            k_d        = '0;
            idx_addr_d = '0;
        end else if (tri_end && !last_tri) begin
            // Next triangle's first index sits right after the previous one's last.
            t_d        = t_q + TW'(1);
            k_d        = '0;
            idx_addr_d = idx_addr_q + IAW'(1);
        end else begin
            case (state_q)
                ST_FETCH_IDX: begin
                    for (int j = 0; j < 3; j++) begin
                        if (k_q == KW'(j + RAM_LATENCY)) idx_d[j] = idx_data_in;
                    end
                    if (phase_end) begin
                        k_d        = '0;
                        vtx_addr_d = idx_q[0];
                    end else begin
                        k_d = k_q + KW'(1);
                        if (k_q < KW'(2)) idx_addr_d = idx_addr_q + IAW'(1);
                    end
                end
                ST_FETCH_VTX: begin
                    for (int j = 0; j < 3; j++) begin
                        if (k_q == KW'(j + RAM_LATENCY)) vert_d[j] = vtx_data_in;
                    end
                    if (phase_end) begin
                        k_d = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                        if (k_q == KW'(0)) vtx_addr_d = idx_q[1];
                        if (k_q == KW'(1)) vtx_addr_d = idx_q[2];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            t_q        <= '0;
            k_q        <= '0;
            idx_addr_q <= '0;
            vtx_addr_q <= '0;
            idx_q      <= '0;
            vert_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            t_q        <= t_d;
            k_q        <= k_d;
            idx_addr_q <= idx_addr_d;
            vtx_addr_q <= vtx_addr_d;
            idx_q      <= idx_d;
            vert_q     <= vert_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign idx_addr_out  = idx_addr_q;
    assign vtx_addr_out  = vtx_addr_q;
    assign vert1_out     = vert_q[0];
    assign vert2_out     = vert_q[1];
    assign vert3_out     = vert_q[2];
    assign tri_valid_out = valid_q;
    assign obj_done_out  = done_q;
    assign busy_out      = busy_q;
    assign overrun_out   = overrun_q;

endmodule
